// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multicycle_ctrl                                               |
// | Purpose  : RV32I multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT)   |
// |            with memory wait timeout and sticky halt/error.               |
// | Option   : MULTICYCLE_CTRL_PERF_CNT_EN enables cycle/instret counters.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        halt,
  output logic        err,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam logic [2:0] c_FETCH  = 3'd0;
  localparam logic [2:0] c_DECODE = 3'd1;
  localparam logic [2:0] c_EXEC   = 3'd2;
  localparam logic [2:0] c_MEM    = 3'd3;
  localparam logic [2:0] c_WB     = 3'd4;
  localparam logic [2:0] c_HALT   = 3'd5;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  // The request times out on the TIMEOUT-th consecutive cycle without ready.
  localparam logic [TIMEOUT_W-1:0] c_LAST_WAIT = TIMEOUT_W'(TIMEOUT - 1);

  logic [2:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 halt_q, halt_d;
  logic                 err_q, err_d;
  logic                 w_err_set;

  logic [6:0] w_opcode;
  logic       w_is_r, w_is_imm, w_is_load, w_is_store, w_is_branch;
  logic       w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_is_system;
  logic       w_legal, w_use_imm, w_rd_nz, w_wait_last;
  logic       w_unused;

  assign w_opcode    = instr[6:0];
  assign w_is_r      = (w_opcode == c_OP_R);
  assign w_is_imm    = (w_opcode == c_OP_IMM);
  assign w_is_load   = (w_opcode == c_OP_LOAD);
  assign w_is_store  = (w_opcode == c_OP_STORE);
  assign w_is_branch = (w_opcode == c_OP_BRANCH);
  assign w_is_jal    = (w_opcode == c_OP_JAL);
  assign w_is_jalr   = (w_opcode == c_OP_JALR);
  assign w_is_lui    = (w_opcode == c_OP_LUI);
  assign w_is_auipc  = (w_opcode == c_OP_AUIPC);
  assign w_is_system = (w_opcode == c_OP_SYSTEM);
  assign w_legal     = w_is_r | w_is_imm | w_is_load | w_is_store | w_is_branch |
                       w_is_jal | w_is_jalr | w_is_lui | w_is_auipc | w_is_system;
  assign w_use_imm   = w_is_imm | w_is_load | w_is_store | w_is_jalr | w_is_lui | w_is_auipc;
  assign w_rd_nz     = (instr[11:7] != 5'd0);
  assign w_wait_last = (wait_q == c_LAST_WAIT);
  assign w_unused    = ^instr[31:12];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_FETCH;
      wait_q  <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    w_err_set = 1'b0;
    unique case (state_q)
      c_FETCH: begin
        if (imem_ready) begin
          state_d = c_DECODE;
        end else if (w_wait_last) begin
          state_d   = c_HALT;
          w_err_set = 1'b1;
        end
      end
      c_DECODE: begin
        if (w_is_system) begin
          state_d = c_HALT;
        end else if (!w_legal) begin
          state_d   = c_HALT;
          w_err_set = 1'b1;
        end else begin
          state_d = c_EXEC;
        end
      end
      c_EXEC: begin
        if (w_is_branch)                  state_d = c_FETCH;
        else if (w_is_load || w_is_store) state_d = c_MEM;
        else                              state_d = c_WB;
      end
      c_MEM: begin
        if (dmem_ready) begin
          state_d = w_is_store ? c_FETCH : c_WB;
        end else if (w_wait_last) begin
          state_d   = c_HALT;
          w_err_set = 1'b1;
        end
      end
      c_WB:    state_d = c_FETCH;
      c_HALT:  state_d = c_HALT;
      default: state_d = c_FETCH;
    endcase

    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == c_FETCH && !imem_ready) || (state_q == c_MEM && !dmem_ready)) begin
      wait_d = wait_q + TIMEOUT_W'(1);
    end else begin
      wait_d = wait_q;
    end

    halt_d = halt_q | (state_d == c_HALT);
    err_d  = err_q | w_err_set;
  end

  // Output decode; write strobes are suppressed while rst is asserted.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    unique case (state_q)
      c_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      c_EXEC: begin
        alu_src_b = w_use_imm;
        if (w_is_branch) begin
          pc_we  = 1'b1;
          pc_sel = {1'b0, br_taken};
        end
      end
      c_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_store;
        pc_we    = w_is_store & dmem_ready;
      end
      c_WB: begin
        reg_we = w_rd_nz;
        pc_we  = 1'b1;
        if (w_is_load)                   wb_sel = 2'd1;
        else if (w_is_jal || w_is_jalr)  wb_sel = 2'd2;
        if (w_is_jal)                    pc_sel = 2'd1;
        else if (w_is_jalr)              pc_sel = 2'd2;
      end
      default: ;
    endcase
    if (rst) begin
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      pc_we    = 1'b0;
      reg_we   = 1'b0;
    end
  end

  assign halt  = halt_q;
  assign err   = err_q;
  assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != c_HALT) cycle_cnt_q   <= cycle_cnt_q + 32'd1;
      if (pc_we)             instret_cnt_q <= instret_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multicycle_ctrl                                            |
// | Purpose  : Scoreboard bench for multicycle_ctrl; one record per retire   |
// |            (pc_we) or halt entry.                                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        br_taken = 1'b0;
  logic        imem_req, imem_ready = 1'b1;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic        ir_we, pc_we, alu_src_b, reg_we, halt, err;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  multicycle_ctrl #(.TIMEOUT(255), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_b(alu_src_b),
    .reg_we(reg_we), .wb_sel(wb_sel), .halt(halt), .err(err), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat; int pc_sel; int wb_sel; int reg_we; int alu_b;
    int mem; int dwe; int halt; int err;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int evt_cnt = 0;
  int mem_delay = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(int lat, int ps, int ws, int rw, int ab, int mem, int dwe, int h, int e);
    exp_t r;
    r.lat = lat; r.pc_sel = ps; r.wb_sel = ws; r.reg_we = rw; r.alu_b = ab;
    r.mem = mem; r.dwe = dwe; r.halt = h; r.err = e;
    return r;
  endfunction

  // Data memory model: ready on the (mem_delay+1)-th request cycle.
  int mcnt = 0;
  always @(negedge clk) begin
    if (dmem_req && !rst) begin
      dmem_ready = (mcnt == mem_delay);
      mcnt++;
    end else begin
      dmem_ready = 1'b0;
      mcnt = 0;
    end
  end

  // Monitor: accumulates per-instruction observations, compares on each event.
  int  m_lat = 0, m_mem = 0, m_alu_b = 0, m_dwe = 0, m_reg_we = 0;
  bit  m_halt_prev = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      m_lat = 0; m_mem = 0; m_alu_b = 0; m_dwe = 0; m_reg_we = 0;
      m_halt_prev = 1'b0;
    end else begin
      m_lat++;
      if (state == 3'd2) m_alu_b = int'(alu_src_b);
      if (state == 3'd3) begin
        m_mem++;
        if (dmem_we) m_dwe = 1;
      end
      if (reg_we) m_reg_we = 1;
      if (pc_we || (halt && !m_halt_prev)) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("latency",   m_lat,         e.lat);
          chk("pc_sel",    int'(pc_sel),  e.pc_sel);
          chk("wb_sel",    int'(wb_sel),  e.wb_sel);
          chk("reg_we",    m_reg_we,      e.reg_we);
          chk("alu_src_b", m_alu_b,       e.alu_b);
          chk("mem_cycles",m_mem,         e.mem);
          chk("dmem_we",   m_dwe,         e.dwe);
          chk("halt",      int'(halt),    e.halt);
          chk("err",       int'(err),     e.err);
        end
        evt_cnt++;
        m_lat = 0; m_mem = 0; m_alu_b = 0; m_dwe = 0; m_reg_we = 0;
      end
      m_halt_prev = halt;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input bit br, input int md, input exp_t e);
    int start;
    instr = ins; br_taken = br; mem_delay = md;
    sbq.push_back(e);
    start = evt_cnt;
    for (int i = 0; i < 400 && evt_cnt == start; i++) begin
      @(negedge clk);
      #2;
    end
    if (evt_cnt == start) begin
      chk("event_timeout", 0, 1);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int found;
    do_reset();
    #1;
    chk("rst_state",    int'(state),    0);
    chk("rst_imem_req", int'(imem_req), 1);
    chk("rst_strobes",  int'({dmem_req, dmem_we, pc_we, reg_we, alu_src_b}), 0);
    chk("rst_sel",      int'({pc_sel, wb_sel}), 0);
    chk("rst_halt_err", int'({halt, err}), 0);

    //                         lat ps ws rw ab mem dwe h  e
    run_instr(32'h00500093, 0, 0, mk(4, 0, 0, 1, 1, 0, 0, 0, 0));  // addi x1,x0,5
    run_instr(32'h0000A103, 0, 3, mk(8, 0, 1, 1, 1, 4, 0, 0, 0));  // lw x2,0(x1), 3 late
    run_instr(32'h00000463, 1, 0, mk(3, 1, 0, 0, 0, 0, 0, 0, 0));  // beq taken
    run_instr(32'h00000463, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 0, 0));  // beq not taken
    run_instr(32'h00102023, 0, 0, mk(4, 0, 0, 0, 1, 1, 1, 0, 0));  // sw x1,0(x0)
    run_instr(32'h008000EF, 0, 0, mk(4, 1, 2, 1, 0, 0, 0, 0, 0));  // jal x1,8
    run_instr(32'h000100E7, 0, 0, mk(4, 2, 2, 1, 1, 0, 0, 0, 0));  // jalr x1,0(x2)
    run_instr(32'h000011B7, 0, 0, mk(4, 0, 0, 1, 1, 0, 0, 0, 0));  // lui x3
    run_instr(32'h00500013, 0, 0, mk(4, 0, 0, 0, 1, 0, 0, 0, 0));  // addi x0 (suppressed)
    run_instr(32'h00102023, 0, 100000, mk(259, 0, 0, 0, 1, 255, 1, 1, 1));  // sw, ready stuck

    do_reset();
    #1;
    chk("post_timeout_state", int'(state), 0);
    chk("post_timeout_err",   int'(err),   0);
    chk("post_timeout_halt",  int'(halt),  0);
    run_instr(32'hFFFFFFFF, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 1));  // illegal
    do_reset();
    run_instr(32'h00000073, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 0));  // ecall
    do_reset();

    // Reset while a load is waiting in MEM.
    instr = 32'h0000A103; mem_delay = 100000;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      #2;
      if (state == 3'd3) found = 1;
    end
    chk("reach_mem", found, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_dmem_req", int'(dmem_req), 0);
    chk("midrst_writes",   int'({pc_we, reg_we, dmem_we, ir_we}), 0);
    @(negedge clk);
    #1;
    chk("midrst_state", int'(state), 0);
    mem_delay = 0;

    // Four back-to-back addi at zero wait.
    do_reset();
    instr = 32'h00500093; br_taken = 1'b0;
    for (int k = 0; k < 4; k++) sbq.push_back(mk(4, 0, 0, 1, 1, 0, 0, 0, 0));
    repeat (16) @(negedge clk);
    #2;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    chk("cycle_cnt",   int'(cycle_cnt),   16);
    chk("instret_cnt", int'(instret_cnt), 4);
`else
    chk("cycle_cnt",   int'(cycle_cnt),   0);
    chk("instret_cnt", int'(instret_cnt), 0);
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
